// File: rtl/mul_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : mul_dispatch
// Description : Front/back end for an iterative unsigned multiplier core.
//               Buffers tagged requests in a small FIFO and turns signed
//               operands into magnitudes. It issues one operation at a time
//               to the core, sign-corrects the double-width product and
//               returns the selected half in request order.
//               Optional feature: define MUL_DISPATCH_SHORTCUT_EN to answer
//               zero-operand requests directly without using the core.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_dispatch #(
    parameter int N_BIT = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [N_BIT-1:0]     req_a,
    input  logic [N_BIT-1:0]     req_b,
    input  logic [1:0]           req_op,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N_BIT-1:0]     rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [N_BIT-1:0]     mul_a,
    output logic [N_BIT-1:0]     mul_b,
    output logic                 mul_start,
    input  logic [2*N_BIT-1:0]   mul_out,
    input  logic                 mul_ready,
    output logic                 busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Request FIFO storage and bookkeeping
    logic [N_BIT-1:0] fifo_a   [DEPTH];
    logic [N_BIT-1:0] fifo_b   [DEPTH];
    logic [1:0]       fifo_op  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push, pop, fifo_empty;
    logic [N_BIT-1:0] head_a, head_b;
    logic [1:0]       head_op;
    logic [TAG_W-1:0] head_tag;
    logic             sa, sb;
    logic [N_BIT-1:0] mag_a, mag_b;

    // Registered operation context for the op in flight
    logic                 neg;
    logic [1:0]           op_q;
    logic [2*N_BIT-1:0]   prod_fix;

`ifdef MUL_DISPATCH_SHORTCUT_EN
    logic zero_op;
    assign zero_op = (head_a == '0) || (head_b == '0);
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready is a pure function of the registered count, so a same-cycle pop
    // never opens room for a push.
    assign fifo_empty = (count == '0);
    assign req_ready  = (count != CNT_W'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = (state == S_IDLE) && !fifo_empty;

    assign head_a   = fifo_a[rd_ptr];
    assign head_b   = fifo_b[rd_ptr];
    assign head_op  = fifo_op[rd_ptr];
    assign head_tag = fifo_tag[rd_ptr];

    // a is signed for MULH and MULHSU, b only for MULH; the magnitude of the
    // most negative value is 2^(N-1), which still fits unsigned.
    assign sa    = ((head_op == OP_MULH) || (head_op == OP_MULHSU)) && head_a[N_BIT-1];
    assign sb    = (head_op == OP_MULH) && head_b[N_BIT-1];
    assign mag_a = sa ? (~head_a + 1'b1) : head_a;
    assign mag_b = sb ? (~head_b + 1'b1) : head_b;

    assign prod_fix = neg ? (~mul_out + 1'b1) : mul_out;

    assign rsp_valid = (state == S_RESP);
    assign mul_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE) || !fifo_empty;

    // FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= req_a;
            fifo_b[wr_ptr]   <= req_b;
            fifo_op[wr_ptr]  <= req_op;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
`ifdef MUL_DISPATCH_SHORTCUT_EN
                    state_nxt = zero_op ? S_RESP : S_ISSUE;
`else
                    state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_ready) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture at pop and result capture when the core finishes
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            neg      <= 1'b0;
            op_q     <= OP_MUL;
            rsp_data <= '0;
            rsp_tag  <= '0;
        end else begin
            if (pop) begin
                mul_a   <= mag_a;
                mul_b   <= mag_b;
                neg     <= sa ^ sb;
                op_q    <= head_op;
                rsp_tag <= head_tag;
`ifdef MUL_DISPATCH_SHORTCUT_EN
                if (zero_op) rsp_data <= '0;
`endif
            end
            if ((state == S_WAIT) && mul_ready) begin
                rsp_data <= (op_q == OP_MUL) ? prod_fix[N_BIT-1:0]
                                             : prod_fix[2*N_BIT-1:N_BIT];
            end
        end
    end

endmodule
`default_nettype wire
